// File: rtl/mdu_sequencer_pkg.sv
// Shared encodings for the RV32 M-extension sequencer: funct3/funct7 codes,
// FSM states and the per-op operand signedness rules.
package mdu_sequencer_pkg;

    localparam logic [2:0] MDU_MUL    = 3'b000;
    localparam logic [2:0] MDU_MULH   = 3'b001;
    localparam logic [2:0] MDU_MULHSU = 3'b010;
    localparam logic [2:0] MDU_MULHU  = 3'b011;
    localparam logic [2:0] MDU_DIV    = 3'b100;
    localparam logic [2:0] MDU_DIVU   = 3'b101;
    localparam logic [2:0] MDU_REM    = 3'b110;
    localparam logic [2:0] MDU_REMU   = 3'b111;

    localparam logic [6:0] OPCODE_ARITH_R_MDU_F7 = 7'b0000001;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } mdu_state_e;

    function automatic logic rs1_is_signed(input logic [2:0] f3);
        return (f3 == MDU_MUL) || (f3 == MDU_MULH) || (f3 == MDU_MULHSU) ||
               (f3 == MDU_DIV) || (f3 == MDU_REM);
    endfunction

    function automatic logic rs2_is_signed(input logic [2:0] f3);
        return (f3 == MDU_MUL) || (f3 == MDU_MULH) ||
               (f3 == MDU_DIV) || (f3 == MDU_REM);
    endfunction

endpackage

// File: rtl/mdu_divstep.sv
// One restoring-division step: trial-subtract the divisor from the shifted
// partial remainder and keep the difference only when it does not go negative.
module mdu_divstep #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   rem_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN-1:0] rem_o,
    output logic            q_o
);

    logic [XLEN:0] diff;

    assign diff  = rem_i - {1'b0, divisor_i};
    assign q_o   = ~diff[XLEN];
    // The kept remainder is always below the divisor, so it fits in XLEN bits.
    assign rem_o = q_o ? diff[XLEN-1:0] : rem_i[XLEN-1:0];

endmodule

// File: rtl/mdu_sequencer.sv
// Iterative RV32 M-extension unit: shift-add multiply and restoring divide,
// one bit per cycle, stalling the pipeline until a one-cycle done pulse.
module mdu_sequencer
    import mdu_sequencer_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            flush,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            stall,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [1:0]      dbg_state
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic              sign_a_q, sign_a_d;
    logic              sign_b_q, sign_b_d;
    logic [XLEN-1:0]   mag_a_q, mag_a_d;
    logic [XLEN-1:0]   mag_b_q, mag_b_d;
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic [XLEN-1:0]   rem_q, rem_d;
    logic [XLEN-1:0]   quo_q, quo_d;
    logic [XLEN-1:0]   result_q, result_d;

    logic              in_sign_a, in_sign_b;
    logic [XLEN-1:0]   in_mag_a, in_mag_b;
    logic              div_by_zero, div_overflow;
    logic [XLEN:0]     mul_sum;
    logic [XLEN-1:0]   step_rem;
    logic              step_q;
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix;

    mdu_divstep #(.XLEN(XLEN)) u_divstep (
        .rem_i     ({rem_q, quo_q[XLEN-1]}),
        .divisor_i (mag_b_q),
        .rem_o     (step_rem),
        .q_o       (step_q)
    );

    always_comb begin
        in_sign_a    = rs1_is_signed(funct3) & rs1[XLEN-1];
        in_sign_b    = rs2_is_signed(funct3) & rs2[XLEN-1];
        in_mag_a     = in_sign_a ? -rs1 : rs1;
        in_mag_b     = in_sign_b ? -rs2 : rs2;
        div_by_zero  = funct3[2] && (rs2 == '0);
        // Only DIV (100) and REM (110) are signed divides; funct3[0] marks unsigned.
        div_overflow = funct3[2] && !funct3[0] && (rs1 == INT_MIN) && (rs2 == '1);

        mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mag_a_q} : '0);
        prod_fix = (sign_a_q ^ sign_b_q) ? -prod_q : prod_q;
        quo_fix  = (sign_a_q ^ sign_b_q) ? -quo_q : quo_q;
        rem_fix  = sign_a_q ? -rem_q : rem_q;

        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        mag_a_d  = mag_a_q;
        mag_b_d  = mag_b_q;
        prod_d   = prod_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        result_d = result_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start && !flush) begin
                    op_d     = funct3;
                    sign_a_d = in_sign_a;
                    sign_b_d = in_sign_b;
                    mag_a_d  = in_mag_a;
                    mag_b_d  = in_mag_b;
                    cnt_d    = '0;
                    prod_d   = {{XLEN{1'b0}}, in_mag_b};
                    rem_d    = '0;
                    quo_d    = in_mag_a;
                    if (div_by_zero) begin
                        result_d = funct3[1] ? rs1 : '1;
                        state_d  = ST_DONE;
                    end else if (div_overflow) begin
                        result_d = funct3[1] ? '0 : INT_MIN;
                        state_d  = ST_DONE;
                    end else begin
                        state_d  = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                cnt_d = cnt_q + 1'b1;
                if (op_q[2]) begin
                    rem_d = step_rem;
                    quo_d = {quo_q[XLEN-2:0], step_q};
                end else begin
                    prod_d = {mul_sum, prod_q[XLEN-1:1]};
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                if (!op_q[2]) begin
                    result_d = (op_q == MDU_MUL) ? prod_fix[XLEN-1:0] : prod_fix[2*XLEN-1:XLEN];
                end else begin
                    result_d = op_q[1] ? rem_fix : quo_fix;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A redirect kills whatever is in flight without touching the visible result.
        if (flush) begin
            state_d  = ST_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            mag_a_q  <= '0;
            mag_b_q  <= '0;
            prod_q   <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            mag_a_q  <= mag_a_d;
            mag_b_q  <= mag_b_d;
            prod_q   <= prod_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            result_q <= result_d;
        end
    end

    assign stall     = ((state_q == ST_IDLE) && start && !flush) ||
                       (state_q == ST_CALC) || (state_q == ST_FIX);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign result    = result_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed bench for mdu_sequencer: arithmetic reference model, cycle-window
// expectations for stall/busy/done, and literal pins for each vector.
module tb_mdu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        flush = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] rs1 = 32'd0;
    logic [31:0] rs2 = 32'd0;
    logic        stall, busy, done;
    logic [31:0] result;
    logic [1:0]  dbg_state;

    mdu_sequencer #(.XLEN(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .flush     (flush),
        .funct3    (funct3),
        .rs1       (rs1),
        .rs2       (rs2),
        .stall     (stall),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    // ---------------- scoreboard state ----------------
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] model_res = 32'd0;
    int          stall_from = -1, stall_to = -2;
    int          busy_from = -1, busy_to = -2;
    int          done_at = -1;
    int          last_done_cyc = -1;
    bit          chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
        end
    endtask

    // Reference arithmetic straight from the ISA definition.
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ua, ub;
        logic [63:0] p;
        int          sq;
        bit          ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'({32'd0, a});
        ub  = longint'({32'd0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = 64'(sa * sb); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = 64'(ua * ub); return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                sq = $signed(a) / $signed(b);
                return 32'(sq);
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (ovf) return 32'd0;
                sq = $signed(a) % $signed(b);
                return 32'(sq);
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        return f[2] && ((b == 32'd0) ||
               (!f[0] && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)));
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            if (cyc == done_at) begin
                if (exp_q.size() > 0) model_res = exp_q.pop_front();
                else check("exp_q_empty", 32'd1, 32'd0);
            end
            check("done", {31'd0, done}, {31'd0, cyc == done_at});
            check("busy", {31'd0, busy}, {31'd0, (cyc >= busy_from) && (cyc <= busy_to)});
            check("stall", {31'd0, stall}, {31'd0, (cyc >= stall_from) && (cyc <= stall_to)});
            check("result", result, model_res);
            if (done) last_done_cyc = cyc;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic set_windows(input int c, input int lat);
        stall_from = c;
        stall_to   = c + lat - 1;
        busy_from  = c + 1;
        busy_to    = c + lat;
        done_at    = c + lat;
    endtask

    // Issue one M-op; start is held through DONE like the real pipeline, and the
    // operand buses are scrambled after acceptance to prove they were latched.
    task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] lit);
        int c;
        int lat;
        c   = cyc;
        lat = is_special(f, a, b) ? 1 : 34;
        start = 1'b1; funct3 = f; rs1 = a; rs2 = b;
        set_windows(c, lat);
        exp_q.push_back(model(f, a, b));
        check({name, "_model"}, model(f, a, b), lit);
        next_cycle();
        while (cyc <= c + lat) begin
            funct3 = 3'($urandom_range(0, 7));
            rs1    = $urandom;
            rs2    = $urandom;
            next_cycle();
        end
        start = 1'b0;
        check({name, "_result"}, result, lit);
        check({name, "_latency"}, 32'(last_done_cyc - c), 32'(lat));
    endtask

    // Start an op, then kill it after 'after' cycles with flush or reset.
    task automatic abort_op(input string name, input logic [2:0] f, input logic [31:0] a,
                            input logic [31:0] b, input int after, input bit use_reset);
        int c;
        c = cyc;
        start = 1'b1; funct3 = f; rs1 = a; rs2 = b;
        set_windows(c, 34);
        exp_q.push_back(model(f, a, b));
        repeat (after) next_cycle();
        start = 1'b0;
        if (use_reset) rst_n = 1'b0;
        else flush = 1'b1;
        busy_to  = cyc;
        stall_to = cyc;
        done_at  = -1;
        exp_q.delete();
        next_cycle();
        rst_n = 1'b1;
        flush = 1'b0;
        if (use_reset) model_res = 32'd0;
        #1;
        check({name, "_state"}, {30'd0, dbg_state}, 32'd0);
        check({name, "_busy"}, {31'd0, busy}, 32'd0);
        check({name, "_result"}, result, model_res);
        next_cycle();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_n = 1'b0;
        next_cycle();
        check("rst_state", {30'd0, dbg_state}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_stall", {31'd0, stall}, 32'd0);
        chk_en = 1'b1;
        next_cycle();
        rst_n = 1'b1;
        next_cycle();

        run_op("mul_7_m3",    3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB);
        run_op("mulh_min_m1", 3'd1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000);
        run_op("mulhsu_min",  3'd2, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000);
        run_op("mulhu_min",   3'd3, 32'h8000_0000,  32'hFFFF_FFFF, 32'h7FFF_FFFF);
        run_op("div_m7_2",    3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD);
        run_op("rem_m7_2",    3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF);
        run_op("divu_100_7",  3'd5, 32'd100,        32'd7,         32'd14);
        run_op("remu_100_7",  3'd7, 32'd100,        32'd7,         32'd2);
        run_op("div_by_0",    3'd4, 32'h0000_1234,  32'd0,         32'hFFFF_FFFF);
        run_op("remu_by_0",   3'd7, 32'h0000_1234,  32'd0,         32'h0000_1234);
        run_op("div_ovf",     3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000);
        run_op("rem_ovf",     3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'h0000_0000);
        run_op("rem_by_0",    3'd6, 32'hFFFF_FFF9,  32'd0,         32'hFFFF_FFF9);
        run_op("divu_by_0",   3'd5, 32'h0000_1234,  32'd0,         32'hFFFF_FFFF);
        run_op("mulh_m5_3",   3'd1, 32'hFFFF_FFFB,  32'd3,         32'hFFFF_FFFF);
        run_op("mulhu_max",   3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("rem_7_m2",    3'd6, 32'd7,          32'hFFFF_FFFE, 32'd1);
        run_op("div_7_m2",    3'd4, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD);
        run_op("divu_max_1",  3'd5, 32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF);

        // start together with flush in IDLE must not be accepted
        start = 1'b1; flush = 1'b1; funct3 = 3'd5; rs1 = 32'd9; rs2 = 32'd3;
        next_cycle();
        start = 1'b0; flush = 1'b0;
        check("start_flush_busy", {31'd0, busy}, 32'd0);
        next_cycle();

        abort_op("flush_calc10", 3'd0, 32'd5, 32'd6, 11, 1'b0);
        run_op("divu_9_3",    3'd5, 32'd9,          32'd3,         32'd3);
        abort_op("reset_calc", 3'd4, 32'd100, 32'd7, 6, 1'b1);
        check("reset_calc_stall", {31'd0, stall}, 32'd0);
        run_op("remu_after",  3'd7, 32'd100,        32'd7,         32'd2);

        next_cycle();
        chk_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu_sequencer.md
# mdu_sequencer

Multi-cycle sequencer for the RV32 M-extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU). It sits beside the ALU in the execute stage. The control unit routes OP-type instructions with funct7 = 0000001 here instead of to the ALU. The block computes the result iteratively (one bit per cycle), holds the pipeline with a stall signal while it runs, and delivers a one-cycle `done` pulse with the result.

## Interface
- `XLEN`, 32, operand and result width; the iteration count equals `XLEN`.
- `clk` input 1: rising-edge clock.
- `rst_n` input 1: synchronous, active-low reset.
- `start` input 1: M-instruction valid in execute. Held high by the pipeline while `stall` is high.
- `flush` input 1: kill the in-flight operation (branch/jump redirect).
- `funct3` input 3: M-op select. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `rs1` input XLEN: operand A (dividend or multiplicand).
- `rs2` input XLEN: operand B (divisor or multiplier).
- `stall` output 1: freeze PC, IF/ID and ID/EX.
- `busy` output 1: state is not IDLE.
- `done` output 1: one-cycle pulse; `result` is valid in this cycle.
- `result` output XLEN: final value, held until the next accepted `start`.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE, `start`=1, `flush`=0: latch `funct3`, operand magnitudes and sign flags; clear the iteration counter.
  - Special case, next state DONE: divide/remainder with `rs2`=0, or signed DIV/REM with `rs1`=0x80000000 and `rs2`=0xFFFFFFFF.
  - Otherwise, next state CALC.
- Signedness:
  - MUL, MULH, DIV, REM: both operands signed.
  - MULHSU: `rs1` signed, `rs2` unsigned.
  - MULHU, DIVU, REMU: both operands unsigned.
  - Magnitude = two's-complement negate when the operand is signed and its MSB is 1.
- CALC multiply: shift-add over a 2·XLEN product register, one multiplier bit per cycle.
- CALC divide: restoring division, one quotient bit per cycle. Partial remainder is XLEN+1 bits; quotient shifts in from the LSB.
- Iteration counter runs 0 to XLEN−1. At XLEN−1, go to FIX.
- FIX: apply sign correction and select the result.
  - Product negated if sign(A) XOR sign(B), then low word for MUL, high word for MULH/MULHSU/MULHU.
  - Quotient negated if signs differ.
  - Remainder takes the sign of the dividend.
  - Register `result`; go to DONE.
- Special-case results, registered in the IDLE→DONE transition:
  - Divide by zero: quotient 0xFFFFFFFF; remainder = `rs1`.
  - Signed overflow: quotient 0x80000000; remainder 0.
- DONE: `done`=1 for exactly one cycle, then IDLE unconditionally. `start` is ignored in DONE, because it is still the same instruction leaving the stage.
- `stall` = (state==IDLE & `start` & ~`flush`) | state==CALC | state==FIX. `stall` is low in DONE, so the pipeline advances and captures `result`.
- `flush` in any state: next state IDLE; no `done`; `result` keeps its old value.
- `start` while CALC/FIX: ignored; the operands latched at acceptance are used.

## Timing
- Reset (`rst_n`=0 at a rising edge) values: state IDLE, `result`=0, `done`=0, `busy`=0, `stall`=0, counter 0. Reset mid-operation abandons the operation.
- Normal latency: start accepted at edge E0 → CALC for XLEN cycles → FIX 1 cycle → `done` high during the cycle after edge E0+XLEN+1. For XLEN=32, that is the 34th cycle after E0.
- Special-case latency: `done` high in the cycle after E0.
- `stall` is combinational from `start` in IDLE. All other outputs are registered.
- Back-to-back M instructions: the second `start` is accepted earliest in the IDLE cycle after DONE.

## Structure
- Add to `defines.v`:
  - M-op funct3 codes (`MDU_MUL` … `MDU_REMU`).
  - `OPCODE_Arith_R` funct7 value 0000001.
  - 2-bit state encodings for IDLE/CALC/FIX/DONE.
- Sub-module `mdu_divstep`: combinational single restoring-division step (partial remainder, divisor → next remainder, quotient bit). It is instantiated once.
- Multiply accumulate, the counter and the FSM stay in `mdu_sequencer`.

## Test plan
- MUL, `rs1`=7, `rs2`=−3 (0xFFFFFFFD) → `done` in the 34th cycle after accept, `result`=0xFFFFFFEB; `stall` high from the start cycle through FIX, low in DONE.
- MULH / MULHSU / MULHU, `rs1`=0x80000000, `rs2`=0xFFFFFFFF → `result` = 0x00000000 / 0x80000000 / 0x7FFFFFFF respectively.
- DIV, `rs1`=−7, `rs2`=2 → `result` 0xFFFFFFFD. REM with the same operands → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- DIV and REMU with `rs2`=0, `rs1`=0x1234 → DIV 0xFFFFFFFF, REMU 0x1234. DIV 0x80000000/−1 → 0x80000000. All three with `done` in the cycle after accept.
- `flush` at CALC cycle 10 → IDLE next cycle, no `done` pulse, `result` unchanged. A fresh DIVU 9/3 afterwards → `result` 3.
- `rst_n` low for one edge during CALC → all outputs 0 and state IDLE. `start` held high through DONE → exactly one `done` pulse, no second operation.
